spi_controller: RTL and testbench
=================================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning clk cycles per SCLK half-period (legal 2..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  write request present.
REQ-005 SHALL have port in_ready  output  1  controller can accept a request this cycle.
REQ-006 SHALL have port in_addr  input  7  target register address.
REQ-007 SHALL have port in_data  input  8  value to write.
REQ-008 SHALL have port done  output  1  one-cycle pulse at transaction end.
REQ-009 SHALL have port sclk  output  1  SPI clock, mode 0 (idle low).
REQ-010 SHALL have port mosi  output  1  serial data, MSB first.
REQ-011 SHALL have port cs_n  output  1  chip select, active-low.

Function
REQ-012 Acceptance SHALL occur on a clk edge where in_valid=1 and in_ready=1; in_ready=1 only in IDLE.
REQ-013 On acceptance, the frame SHALL be latched as {1'b1, in_addr, in_data} (16 bits, bit15 = write flag); later input changes are ignored.
REQ-014 FSM states: IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP; no other states.
REQ-015 IDLE->SETUP on acceptance; cs_n=0 and mosi=frame[15] from the first cycle after acceptance.
REQ-016 SETUP SHALL last DIV cycles with sclk=0, then enter SHIFT_HI.
REQ-017 SHIFT_HI SHALL last DIV cycles with sclk=1; SHIFT_LO SHALL last DIV cycles with sclk=0.
REQ-018 mosi SHALL change only on entry to SHIFT_LO (sclk falling), presenting the next lower frame bit; it is stable throughout each SHIFT_HI.
REQ-019 Exactly 16 sclk rising edges SHALL occur per transaction; after the 16th SHIFT_LO, go to GAP.
REQ-020 cs_n SHALL stay low for exactly 33*DIV consecutive cycles; the final SHIFT_LO serves as CS hold time.
REQ-021 On entry to GAP: cs_n=1, mosi=0, done=1 for exactly that one cycle.
REQ-022 GAP SHALL last DIV cycles (minimum cs_n-high time), then IDLE; earliest next acceptance is the first IDLE cycle.
REQ-023 in_valid asserted outside IDLE SHALL be ignored, not queued.
REQ-024 A half-period counter (ceil(log2(DIV)) bits, counting 0..DIV-1) and a 5-bit bit counter (0..16) SHALL time all states; no wrap beyond 16.
REQ-025 sclk, mosi, cs_n, done, in_ready SHALL be driven directly from flops (glitch-free).

Reset
REQ-026 rst_n=0 SHALL immediately force: state=IDLE, sclk=0, mosi=0, cs_n=1, done=0, in_ready=0, counters and frame=0.
REQ-027 in_ready SHALL become 1 on the first clk edge after rst_n deasserts.
REQ-028 Reset mid-transaction SHALL abort with no done pulse; the partial frame is discarded.

Structure
REQ-029 Shared package spi_pkg SHALL hold FRAME_W=16, ADDR_W=7, DATA_W=8, WRITE_BIT=15 and the FSM state enum.
REQ-030 One sub-module, spi_tick_gen (half-period counter emitting a one-cycle tick every DIV cycles, restartable), SHALL be used; all else stays in spi_controller.

Verification
REQ-031 DIV=4, write addr 0x02 data 0xA5 -> bits sampled at sclk rises = 0x82A5, cs_n low 132 cycles, 16 rises, one done pulse.
REQ-032 DIV=2 boundary, addr 0x7F data 0x00 -> frame 0xFF00, sclk period 4 cycles, cs_n low 66 cycles.
REQ-033 in_valid held with two requests back-to-back, DIV=4 -> second cs_n fall >=5 cycles after first cs_n rise; no merged frames.
REQ-034 Change in_addr/in_data and pulse in_valid mid-transaction -> transmitted frame unchanged, extra request ignored.
REQ-035 Assert rst_n=0 after 7th sclk rise -> cs_n=1, sclk=0 asynchronously, no done; next write 0x84 0x3C transmits 0x843C cleanly.
REQ-036 Monitor throughout -> mosi never changes while sclk=1 and cs_n=0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants, FSM state encoding and frame helper for the SPI write controller.
package spi_pkg;

  localparam int FRAME_W   = 16;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int WRITE_BIT = 15;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    GAP
  } spi_state_e;

  function automatic logic [FRAME_W-1:0] make_frame(input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    logic [FRAME_W-1:0] f;
    f            = {1'b0, addr, data};
    f[WRITE_BIT] = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period counter: pulses tick_o on the last of every DIV cycles; restart_i holds it at zero.
module spi_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// Mode-0 SPI write master: latches a 16-bit {write, addr, data} frame and shifts it out MSB first.
module spi_controller
  import spi_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n
);

  spi_state_e         state_q;
  logic [FRAME_W-1:0] frame_q;
  logic [4:0]         bit_cnt_q;
  logic               sclk_q;
  logic               mosi_q;
  logic               cs_n_q;
  logic               done_q;
  logic               in_ready_q;
  logic               tick;
  logic [FRAME_W-1:0] req_frame;

  assign req_frame = make_frame(in_addr, in_data);

  // Counter is parked at zero while idle so SETUP always gets a full DIV cycles.
  spi_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart_i(state_q == IDLE),
    .tick_o   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            state_q    <= SETUP;
            frame_q    <= req_frame;
            bit_cnt_q  <= '0;
            mosi_q     <= req_frame[FRAME_W-1];
            cs_n_q     <= 1'b0;
            in_ready_q <= 1'b0;
          end
        end
        SETUP: begin
          if (tick) begin
            state_q <= SHIFT_HI;
            sclk_q  <= 1'b1;
          end
        end
        SHIFT_HI: begin
          // Falling edge: advance to the next lower bit; after bit 0 a zero shifts in.
          if (tick) begin
            state_q   <= SHIFT_LO;
            sclk_q    <= 1'b0;
            frame_q   <= {frame_q[FRAME_W-2:0], 1'b0};
            mosi_q    <= frame_q[FRAME_W-2];
            bit_cnt_q <= bit_cnt_q + 5'd1;
          end
        end
        SHIFT_LO: begin
          if (tick) begin
            if (bit_cnt_q == 5'(FRAME_W)) begin
              state_q <= GAP;
              cs_n_q  <= 1'b1;
              mosi_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= SHIFT_HI;
              sclk_q  <= 1'b1;
            end
          end
        end
        GAP: begin
          if (tick) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            in_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign done     = done_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_controller.sv
// Checks two controllers (DIV=4 and DIV=2) against a cycle-offset model of the SPI write waveform.
module tb_spi_controller;

  localparam int DV[2] = '{4, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid_s[2];
  logic [6:0] in_addr_s[2];
  logic [7:0] in_data_s[2];
  logic       in_ready_s[2];
  logic       done_s[2];
  logic       sclk_s[2];
  logic       mosi_s[2];
  logic       cs_n_s[2];

  always #5 clk = ~clk;

  spi_controller #(.DIV(4)) u_div4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .in_addr(in_addr_s[0]), .in_data(in_data_s[0]), .done(done_s[0]),
    .sclk(sclk_s[0]), .mosi(mosi_s[0]), .cs_n(cs_n_s[0])
  );

  spi_controller #(.DIV(2)) u_div2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .in_addr(in_addr_s[1]), .in_data(in_data_s[1]), .done(done_s[1]),
    .sclk(sclk_s[1]), .mosi(mosi_s[1]), .cs_n(cs_n_s[1])
  );

  int checks = 0;
  int errors = 0;
  int printed = 0;

  task automatic chk(input int inst, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (printed < 40) begin
        printed++;
        $display("FAIL inst%0d %s: got %0d expected %0d at %0t", inst, name, act, exp, $time);
      end
    end
  endtask

  task automatic timeout_fail(input int inst, input string name);
    checks++;
    errors++;
    $display("FAIL inst%0d %s: timed out waiting at %0t", inst, name, $time);
  endtask

  // Model: while busy, every output is a function of t = cycles since acceptance.
  bit          m_busy[2];
  bit          m_ready[2];
  int          m_t[2];
  logic [15:0] m_frame[2];
  int          m_done_cnt[2];
  int          dut_done_cnt[2];

  logic        prev_sclk[2];
  logic        prev_mosi[2];
  logic        prev_cs[2];
  logic [15:0] cap[2];
  int          rises[2];
  int          cs_low[2];
  int          gap[2];
  bit          seen_end[2];
  int          last_rise_cyc[2];
  int          last_period[2];
  logic [15:0] last_cap[2];
  int          last_low[2];
  int          last_rises[2];
  int          txn_cnt[2];
  int          cyc = 0;

  always @(negedge clk) begin
    int t, nf, d;
    logic e_cs, e_sclk, e_mosi, e_done, e_rdy;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      d = DV[i];
      if (!rst_n) begin
        chk(i, "rst_cs_n", cs_n_s[i], 1);
        chk(i, "rst_sclk", sclk_s[i], 0);
        chk(i, "rst_mosi", mosi_s[i], 0);
        chk(i, "rst_done", done_s[i], 0);
        chk(i, "rst_in_ready", in_ready_s[i], 0);
        m_busy[i] = 0; m_ready[i] = 0; m_t[i] = 0;
        prev_sclk[i] = 0; prev_mosi[i] = 0; prev_cs[i] = 1;
        cap[i] = '0; rises[i] = 0; cs_low[i] = 0; gap[i] = 0; seen_end[i] = 0;
      end else begin
        e_cs = 1; e_sclk = 0; e_mosi = 0; e_done = 0; e_rdy = 0;
        if (m_busy[i]) begin
          t = m_t[i];
          if (t < 33 * d) begin
            e_cs   = 0;
            e_sclk = (t >= d) && ((((t - d) / d) % 2) == 0);
            nf     = t / (2 * d);
            e_mosi = (nf < 16) ? m_frame[i][15 - nf] : 1'b0;
          end else begin
            e_done = (t == 33 * d);
          end
        end else begin
          e_rdy = m_ready[i];
        end
        chk(i, "cs_n", cs_n_s[i], e_cs);
        chk(i, "sclk", sclk_s[i], e_sclk);
        chk(i, "mosi", mosi_s[i], e_mosi);
        chk(i, "done", done_s[i], e_done);
        chk(i, "in_ready", in_ready_s[i], e_rdy);

        // Protocol-level observation independent of the model.
        if (done_s[i]) dut_done_cnt[i]++;
        if (sclk_s[i] && prev_sclk[i] && !cs_n_s[i])
          chk(i, "mosi_stable_hi", mosi_s[i], prev_mosi[i]);
        if (!cs_n_s[i] && prev_cs[i]) begin
          if (seen_end[i]) chk(i, "cs_high_gap_ok", int'(gap[i] >= d + 1), 1);
          cap[i] = '0; rises[i] = 0; cs_low[i] = 0;
        end
        if (sclk_s[i] && !prev_sclk[i] && !cs_n_s[i]) begin
          cap[i] = {cap[i][14:0], mosi_s[i]};
          if (rises[i] > 0) begin
            last_period[i] = cyc - last_rise_cyc[i];
            chk(i, "sclk_period", last_period[i], 2 * d);
          end
          last_rise_cyc[i] = cyc;
          rises[i]++;
        end
        if (!cs_n_s[i]) cs_low[i]++;
        else gap[i]++;
        if (cs_n_s[i] && !prev_cs[i]) begin
          chk(i, "frame_bits", cap[i], m_frame[i]);
          chk(i, "rise_count", rises[i], 16);
          chk(i, "cs_low_len", cs_low[i], 33 * d);
          $display("txn inst%0d div=%0d frame=%04h cs_low=%0d rises=%0d",
                   i, d, cap[i], cs_low[i], rises[i]);
          last_cap[i] = cap[i]; last_low[i] = cs_low[i]; last_rises[i] = rises[i];
          txn_cnt[i]++;
          gap[i] = 1;
          seen_end[i] = 1;
        end
        prev_sclk[i] = sclk_s[i]; prev_mosi[i] = mosi_s[i]; prev_cs[i] = cs_n_s[i];

        // Advance the model to the next cycle using the inputs the DUT will sample.
        if (m_busy[i]) begin
          if (m_t[i] == 33 * d) m_done_cnt[i]++;
          m_t[i]++;
          if (m_t[i] == 34 * d) begin
            m_busy[i] = 0;
            m_ready[i] = 1;
          end
        end else if (m_ready[i] && in_valid_s[i]) begin
          m_busy[i]  = 1;
          m_t[i]     = 0;
          m_frame[i] = {1'b1, in_addr_s[i], in_data_s[i]};
          m_ready[i] = 0;
        end else begin
          m_ready[i] = 1;
        end
      end
    end
  end

  task automatic accept(input int i, input logic [6:0] a, input logic [7:0] d);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    in_addr_s[i] = a; in_data_s[i] = d; in_valid_s[i] = 1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (in_ready_s[i]) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    if (!ok) timeout_fail(i, "accept");
  endtask

  task automatic wait_idle(input int i);
    bit ok;
    ok = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (in_ready_s[i]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout_fail(i, "wait_idle");
  endtask

  initial begin
    int n0, k;
    for (int i = 0; i < 2; i++) begin
      in_valid_s[i] = 0; in_addr_s[i] = '0; in_data_s[i] = '0;
      m_done_cnt[i] = 0; dut_done_cnt[i] = 0; txn_cnt[i] = 0;
      last_cap[i] = '0; last_low[i] = 0; last_rises[i] = 0; last_period[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Basic write at DIV=4.
    accept(0, 7'h02, 8'hA5);
    in_valid_s[0] = 0;
    wait_idle(0);
    chk(0, "lit_frame_82A5", last_cap[0], 16'h82A5);
    chk(0, "lit_cs_low_132", last_low[0], 132);
    chk(0, "lit_rises_16", last_rises[0], 16);
    chk(0, "lit_one_done", dut_done_cnt[0], 1);

    // DIV=2 boundary.
    accept(1, 7'h7F, 8'h00);
    in_valid_s[1] = 0;
    wait_idle(1);
    chk(1, "lit_frame_FF00", last_cap[1], 16'hFF00);
    chk(1, "lit_cs_low_66", last_low[1], 66);
    chk(1, "lit_sclk_period_4", last_period[1], 4);

    // Back-to-back with in_valid held high.
    n0 = txn_cnt[0];
    accept(0, 7'h11, 8'h22);
    accept(0, 7'h33, 8'h44);
    in_valid_s[0] = 0;
    wait_idle(0);
    chk(0, "lit_b2b_count", txn_cnt[0] - n0, 2);
    chk(0, "lit_b2b_second", last_cap[0], 16'hB344);

    // Inputs changed and in_valid pulsed mid-transaction.
    accept(0, 7'h5A, 8'hC3);
    in_valid_s[0] = 0;
    repeat (40) @(posedge clk);
    #1;
    in_addr_s[0] = 7'h01; in_data_s[0] = 8'hFF; in_valid_s[0] = 1;
    @(posedge clk); #1 in_valid_s[0] = 0;
    wait_idle(0);
    chk(0, "lit_midchange_frame", last_cap[0], 16'hDAC3);

    // Randomized traffic on both instances.
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 14; n++) begin
        accept(i, 7'($urandom), 8'($urandom));
        in_valid_s[i] = 0;
        if ($urandom_range(0, 1) == 1) begin
          k = $urandom_range(1, 30 * DV[i]);
          repeat (k) @(posedge clk);
          #1;
          in_addr_s[i] = 7'($urandom); in_data_s[i] = 8'($urandom); in_valid_s[i] = 1;
          @(posedge clk); #1 in_valid_s[i] = 0;
        end
        wait_idle(i);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    end

    // Asynchronous reset after the 7th rising edge aborts the frame.
    n0 = dut_done_cnt[0];
    accept(0, 7'h10, 8'h55);
    in_valid_s[0] = 0;
    k = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (rises[0] >= 7) begin
        k = 1;
        break;
      end
    end
    if (k == 0) timeout_fail(0, "seventh_rise");
    #1 rst_n = 0;
    #1;
    chk(0, "async_rst_cs_n", cs_n_s[0], 1);
    chk(0, "async_rst_sclk", sclk_s[0], 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk(0, "abort_no_done", dut_done_cnt[0] - n0, 0);
    accept(0, 7'h04, 8'h3C);
    in_valid_s[0] = 0;
    wait_idle(0);
    chk(0, "lit_post_reset_843C", last_cap[0], 16'h843C);

    repeat (5) @(posedge clk);
    for (int i = 0; i < 2; i++) chk(i, "done_pulse_total", dut_done_cnt[i], m_done_cnt[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
